// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - data-memory responder: one latched access per request with WAIT_ST wait states
module dm_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int WAIT_ST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_dm_cslt,
    input  logic        ps_dm_wrb,
    input  logic [15:0] dg_dm_add,
    input  logic [15:0] bc_dt,
    output logic [15:0] dm_bc_dt,
    output logic        dm_rd_vld,
    output logic        dm_ps_stall,
    output logic        dm_add_err
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [2:0] WAIT_LD = 3'(WAIT_ST);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wrb_q, wrb_d;
    logic [15:0]       add_q, add_d;
    logic [15:0]       dat_q, dat_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              rd_vld_q, rd_vld_d;
    logic              stall_q, stall_d;
    logic              err_q, err_d;
    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              done;
    logic              mem_we;

    assign idx      = add_q[ADDR_W-1:0];
    assign in_range = (add_q >> ADDR_W) == 16'd0;
    assign done     = (state_q == BUSY) && (cnt_q == 3'd0);
    assign mem_we   = done && wrb_q && in_range;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wrb_d    = wrb_q;
        add_d    = add_q;
        dat_d    = dat_q;
        rdata_d  = rdata_q;
        rd_vld_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ps_dm_cslt) begin
                    wrb_d   = ps_dm_wrb;
                    add_d   = dg_dm_add;
                    dat_d   = bc_dt;
                    cnt_d   = WAIT_LD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                    err_d   = !in_range;
                    if (!wrb_q) begin
                        rd_vld_d = 1'b1;
                        rdata_d  = in_range ? mem_q[idx] : 16'h0000;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered stall mirrors the state we are about to enter.
        stall_d = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            wrb_q    <= 1'b0;
            add_q    <= 16'h0000;
            dat_q    <= 16'h0000;
            rdata_q  <= 16'h0000;
            rd_vld_q <= 1'b0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wrb_q    <= wrb_d;
            add_q    <= add_d;
            dat_q    <= dat_d;
            rdata_q  <= rdata_d;
            rd_vld_q <= rd_vld_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    // Array is never cleared; reset only suppresses a write that has not committed.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[idx] <= dat_q;
        end
    end

    assign dm_bc_dt    = rdata_q;
    assign dm_rd_vld   = rd_vld_q;
    assign dm_ps_stall = stall_q;
    assign dm_add_err  = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - scoreboard bench for dm_ctrl with a memory-array reference model
module tb_dm_ctrl;

    localparam int ADDR_W  = 8;
    localparam int WAIT_ST = 1;
    localparam int DEPTH   = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps_dm_cslt = 1'b0;
    logic        ps_dm_wrb = 1'b0;
    logic [15:0] dg_dm_add = 16'h0;
    logic [15:0] bc_dt = 16'h0;
    logic [15:0] dm_bc_dt;
    logic        dm_rd_vld;
    logic        dm_ps_stall;
    logic        dm_add_err;

    dm_ctrl #(.ADDR_W(ADDR_W), .WAIT_ST(WAIT_ST)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps_dm_cslt (ps_dm_cslt),
        .ps_dm_wrb  (ps_dm_wrb),
        .dg_dm_add  (dg_dm_add),
        .bc_dt      (bc_dt),
        .dm_bc_dt   (dm_bc_dt),
        .dm_rd_vld  (dm_rd_vld),
        .dm_ps_stall(dm_ps_stall),
        .dm_add_err (dm_add_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          err;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_m [DEPTH];
    logic [15:0] last_rd = 16'h0;
    int          cyc = 0;
    int          acc_n = -1;
    int          done_n = -1;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: samples 1ns after each rising edge; cyc equals the index of that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                chk("rst_bc_dt", dm_bc_dt, 16'h0);
                chk("rst_rd_vld", 16'(dm_rd_vld), 16'h0);
                chk("rst_stall", 16'(dm_ps_stall), 16'h0);
                chk("rst_add_err", 16'(dm_add_err), 16'h0);
            end else begin
                chk("stall", 16'(dm_ps_stall), 16'(cyc >= acc_n && cyc < done_n));
                if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_pulse cyc=%0d actual=none required=pulse@%0d", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                if (dm_rd_vld || dm_add_err) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse cyc=%0d actual=rd%0d/err%0d required=none", cyc, dm_rd_vld, dm_add_err);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("pulse_cycle", 16'(cyc), 16'(e.cyc));
                        chk("rd_vld", 16'(dm_rd_vld), 16'(e.rd));
                        chk("add_err", 16'(dm_add_err), 16'(e.err));
                        if (e.rd) begin
                            chk("rd_data", dm_bc_dt, e.data);
                            last_rd = e.data;
                        end else begin
                            chk("bc_dt_hold_w", dm_bc_dt, last_rd);
                        end
                    end
                end else begin
                    chk("bc_dt_hold", dm_bc_dt, last_rd);
                end
            end
        end
    end

    // Drive one access at the current negedge; returns at the negedge after the completion edge.
    task automatic access(input bit wrb, input logic [15:0] add, input logic [15:0] data, input bit garble);
        exp_t e;
        bit   inr;
        ps_dm_cslt = 1'b1;
        ps_dm_wrb  = wrb;
        dg_dm_add  = add;
        bc_dt      = data;
        acc_n      = cyc + 1;
        done_n     = acc_n + 1 + WAIT_ST;
        inr        = (add[15:ADDR_W] == '0);
        e.rd       = !wrb;
        e.err      = !inr;
        e.cyc      = done_n;
        e.data     = 16'h0;
        if (wrb) begin
            if (inr) mem_m[add[ADDR_W-1:0]] = data;
        end else begin
            e.data = inr ? mem_m[add[ADDR_W-1:0]] : 16'h0;
        end
        if (e.rd || e.err) exp_q.push_back(e);
        for (int i = 0; i < WAIT_ST + 1; i++) begin
            @(negedge clk);
            if (garble) begin
                ps_dm_cslt = 1'($urandom_range(0, 1));
                ps_dm_wrb  = 1'($urandom_range(0, 1));
                dg_dm_add  = 16'($urandom);
                bc_dt      = 16'($urandom);
            end else begin
                ps_dm_cslt = 1'b0;
            end
        end
        @(negedge clk);
        ps_dm_cslt = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ps_dm_cslt = 1'b0;
        exp_q.delete();
        acc_n   = -1;
        done_n  = -1;
        last_rd = 16'h0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        @(negedge clk);

        // Give every location a known value.
        for (int a = 0; a < DEPTH; a++) access(1'b1, 16'(a), 16'($urandom), 1'b0);

        access(1'b1, 16'h0012, 16'hBEEF, 1'b0);
        access(1'b0, 16'h0012, 16'h0, 1'b0);
        access(1'b0, 16'h0100, 16'h0, 1'b0);
        access(1'b0, 16'h0000, 16'h0, 1'b0);
        access(1'b1, 16'h8000, 16'hDEAD, 1'b0);
        access(1'b0, 16'h0000, 16'h0, 1'b0);

        // Garbage (including a 0x0055 address) while stalled must be ignored.
        dg_dm_add = 16'h0055;
        access(1'b0, 16'h0012, 16'h0, 1'b1);
        access(1'b0, 16'h0055, 16'h0, 1'b0);

        // Reset during a write's busy phase discards the write.
        begin
            logic [15:0] prior;
            prior = mem_m[8'h20];
            ps_dm_cslt = 1'b1;
            ps_dm_wrb  = 1'b1;
            dg_dm_add  = 16'h0020;
            bc_dt      = 16'h1234;
            acc_n      = cyc + 1;
            done_n     = acc_n + 1 + WAIT_ST;
            @(negedge clk);
            do_reset(1);
            @(negedge clk);
            chk("mem_prior_model", mem_m[8'h20], prior);
            access(1'b0, 16'h0020, 16'h0, 1'b0);
        end

        for (int k = 0; k < 400; k++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            access(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    dg_dm_add = 16'($urandom);
                    @(negedge clk);
                end
            end
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
